// File: rtl/snap_vacc_capture_ctrl_pkg.sv
// Shared constants and state type for the vacc snapshot capture controller.
package snap_ctrl_pkg;

    localparam int CTRL_ARM_BIT  = 0;
    localparam int CTRL_TRIG_BIT = 1;
    localparam int CTRL_WE_BIT   = 2;

    localparam int STAT_DONE_BIT = 31;
    localparam int STAT_BUSY_BIT = 30;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_CAPTURE,
        S_DONE
    } snap_state_t;

    function automatic logic state_is_busy(input snap_state_t s);
        return (s == S_ARMED) || (s == S_CAPTURE);
    endfunction

endpackage

// File: rtl/snap_vacc_capture_ctrl_if.sv
// Control word, sample stream, BRAM write port and status bundle of the capture controller.
interface snap_vacc_capture_ctrl_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 10
);
    logic [31:0]       ctrl_word;
    logic [DATA_W-1:0] din;
    logic              din_valid;
    logic              din_we;
    logic              trig;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_data;
    logic              bram_we;
    logic              busy;
    logic              done;
    logic [31:0]       status_word;

    modport master (
        output ctrl_word, din, din_valid, din_we, trig,
        input  bram_addr, bram_data, bram_we, busy, done, status_word
    );

    modport slave (
        input  ctrl_word, din, din_valid, din_we, trig,
        output bram_addr, bram_data, bram_we, busy, done, status_word
    );
endinterface

// File: rtl/snap_vacc_capture_ctrl_arm_edge.sv
// Rising-edge detector for the software arm bit; emits a one-cycle pulse.
module snap_arm_edge (
    input  logic user_clk,
    input  logic user_rst_n,
    input  logic arm_i,
    output logic arm_edge_o
);
    logic arm_q;

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            arm_q <= 1'b0;
        end else begin
            arm_q <= arm_i;
        end
    end

    assign arm_edge_o = arm_i & ~arm_q;
endmodule

// File: rtl/snap_vacc_capture_ctrl.sv
// Snapshot capture engine: arm, optional trigger, fill the BRAM once, report done/busy/count.
module snap_vacc_capture_ctrl
    import snap_ctrl_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 10
) (
    input  logic                     user_clk,
    input  logic                     user_rst_n,
    snap_vacc_capture_ctrl_if.slave  bus
);
    localparam logic [ADDR_W:0] COUNT_FULL = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] COUNT_LAST = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W:0] COUNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    snap_state_t       state_q, state_d;
    logic              use_trig_q, use_trig_d;
    logic              use_we_q, use_we_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              arm_edge;
    logic              qual;
    logic              wr;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              busy_q;
    logic              done_q;
    logic [31:0]       status_q, status_d;
    logic              unused_ctrl;

    assign unused_ctrl = ^bus.ctrl_word[31:3];

    snap_arm_edge u_arm_edge (
        .user_clk   (user_clk),
        .user_rst_n (user_rst_n),
        .arm_i      (bus.ctrl_word[CTRL_ARM_BIT]),
        .arm_edge_o (arm_edge)
    );

    assign qual = bus.din_valid & (~use_we_q | bus.din_we);

    // An arm edge takes priority over everything, so a write due in that cycle is dropped.
    always_comb begin
        state_d    = state_q;
        use_trig_d = use_trig_q;
        use_we_d   = use_we_q;
        count_d    = count_q;
        wr         = 1'b0;

        if (arm_edge) begin
            use_trig_d = bus.ctrl_word[CTRL_TRIG_BIT];
            use_we_d   = bus.ctrl_word[CTRL_WE_BIT];
            count_d    = '0;
            state_d    = bus.ctrl_word[CTRL_TRIG_BIT] ? S_ARMED : S_CAPTURE;
        end else begin
            case (state_q)
                S_ARMED: begin
                    if (bus.trig && bus.din_valid) begin
                        state_d = S_CAPTURE;
                        wr      = qual;
                    end
                end
                S_CAPTURE: wr = qual && (count_q != COUNT_FULL);
                default: ;
            endcase

            if (wr) begin
                count_d = count_q + COUNT_ONE;
                if (count_q == COUNT_LAST) begin
                    state_d = S_DONE;
                end
            end
        end
    end

    always_comb begin
        status_d                = '0;
        status_d[ADDR_W:0]      = count_q;
        status_d[STAT_BUSY_BIT] = busy_q;
        status_d[STAT_DONE_BIT] = done_q;
    end

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state_q    <= S_IDLE;
            use_trig_q <= 1'b0;
            use_we_q   <= 1'b0;
            count_q    <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            status_q   <= '0;
        end else begin
            state_q    <= state_d;
            use_trig_q <= use_trig_d;
            use_we_q   <= use_we_d;
            count_q    <= count_d;
            we_q       <= wr;
            if (wr) begin
                addr_q <= count_q[ADDR_W-1:0];
                data_q <= bus.din;
            end
            busy_q     <= state_is_busy(state_q);
            done_q     <= (state_q == S_DONE) && !arm_edge;
            status_q   <= status_d;
        end
    end

    assign bus.bram_we     = we_q;
    assign bus.bram_addr   = addr_q;
    assign bus.bram_data   = data_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.status_word = status_q;
endmodule
